// File: rtl/watchdog_timer_unit.sv
`default_nettype none
// ============================================================================
// Module   : watchdog_timer_unit
// Purpose  : Supervisory watchdog. It raises warning at WARN_CYCLES and
//            force_reset at TIMEOUT_CYCLES unless heartbeat restarts it.
// Options  : WDT_PULSE_OUT_EN makes force_reset a one-cycle pulse; otherwise
//            force_reset is a level.
// Revision : 1.0 - initial release
// ============================================================================
module watchdog_timer_unit #(
    parameter int TIMEOUT_CYCLES = 125_000_000,
    parameter int WARN_CYCLES    = 93_750_000,
    parameter int CNT_W          = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic heartbeat,
    output logic warning,
    output logic force_reset
);

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_WARN    = CNT_W'(WARN_CYCLES);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_warning;
    logic             w_warning_nxt;
    logic             r_triggered;
    logic             w_triggered_nxt;

    // Disarm and kick both clear the count. Once tripped, the count saturates.
    // The >= test also keeps the counter from wrapping.
    always_comb begin
        w_count_nxt = r_count;
        if (!enable || heartbeat) begin
            w_count_nxt = '0;
        end else if (r_triggered || (r_count >= c_TIMEOUT)) begin
            w_count_nxt = c_TIMEOUT;
        end else begin
            w_count_nxt = r_count + c_ONE;
        end
    end

    assign w_warning_nxt   = (w_count_nxt >= c_WARN);
    assign w_triggered_nxt = (w_count_nxt >= c_TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_warning   <= 1'b0;
            r_triggered <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_warning   <= w_warning_nxt;
            r_triggered <= w_triggered_nxt;
        end
    end

    assign warning = r_warning;

`ifdef WDT_PULSE_OUT_EN
    logic r_force_pulse;

    // The pulse register shares the trip edge with r_triggered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_force_pulse <= 1'b0;
        end else begin
            r_force_pulse <= w_triggered_nxt & ~r_triggered;
        end
    end

    assign force_reset = r_force_pulse;
`else
    assign force_reset = r_triggered;
`endif

endmodule
`default_nettype wire

// File: tb/tb_watchdog_timer_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_watchdog_timer_unit
// Purpose  : Self-checking bench for watchdog_timer_unit with TIMEOUT=4 and
//            WARN=3. It follows the WDT_PULSE_OUT_EN build option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_watchdog_timer_unit;

    logic clk;
    logic rst;
    logic enable;
    logic heartbeat;
    logic warning;
    logic force_reset;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic en;
        logic hb;
        logic exp_w;
        logic exp_lvl;
    } vec_t;

    typedef struct {
        string name;
        logic  exp_w;
        logic  exp_f;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t e;

    watchdog_timer_unit #(
        .TIMEOUT_CYCLES(4),
        .WARN_CYCLES   (3),
        .CNT_W         (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .heartbeat  (heartbeat),
        .warning    (warning),
        .force_reset(force_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act_w, input logic act_f,
                       input logic exp_w, input logic exp_f);
        checks = checks + 1;
        if (act_w !== exp_w) begin
            errors = errors + 1;
            $display("FAIL %s warning: got %b expected %b", name, act_w, exp_w);
        end
        checks = checks + 1;
        if (act_f !== exp_f) begin
            errors = errors + 1;
            $display("FAIL %s force_reset: got %b expected %b", name, act_f, exp_f);
        end
    endtask

    function automatic void add(input logic en, input logic hb,
                                input logic w, input logic lvl);
        vec_t v;
        v.en      = en;
        v.hb      = hb;
        v.exp_w   = w;
        v.exp_lvl = lvl;
        vecs.push_back(v);
    endfunction

    // Expected force_reset for a trip after a fresh start, k edges in.
    function automatic logic force_at(input int k);
`ifdef WDT_PULSE_OUT_EN
        return (k == 4);
`else
        return (k >= 4);
`endif
    endfunction

    task automatic run_idle(input string tag);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_edge%0d", tag, k), warning, force_reset,
                (k >= 3), force_at(k));
        end
    endtask

    // Scoreboard consumer: checks one edge after each vector is driven.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, warning, force_reset, e.exp_w, e.exp_f);
        end
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic prev_lvl;
        exp_t x;

        // Timeout run from rst release, held after the trip.
        add(1,0,0,0); add(1,0,0,0); add(1,0,1,0); add(1,0,1,1);
        add(1,0,1,1); add(1,0,1,1);
        // A kick recovers from the trip.
        add(1,1,0,0);
        // Count to 3, kick, then four idle edges to the next trip.
        add(1,0,0,0); add(1,0,0,0); add(1,0,1,0); add(1,1,0,0);
        add(1,0,0,0); add(1,0,0,0); add(1,0,1,0); add(1,0,1,1);
        // A kick on the would-be timeout edge wins.
        add(1,1,0,0); add(1,0,0,0); add(1,0,0,0); add(1,0,1,0);
        add(1,1,0,0); add(1,0,0,0);
        // Enable drop at count 2, held low for 10 edges plus a kick.
        add(1,0,0,0); add(0,0,0,0);
        for (int i = 0; i < 10; i++) add(0,0,0,0);
        add(0,1,0,0);
        // A full count from zero, then disarm clears the trip.
        add(1,0,0,0); add(1,0,0,0); add(1,0,1,0); add(1,0,1,1);
        add(0,0,0,0); add(1,0,0,0); add(0,0,0,0);

        rst       = 1'b1;
        enable    = 1'b0;
        heartbeat = 1'b0;
        #1;
        chk("reset_no_edge", warning, force_reset, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        prev_lvl = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            enable    = vecs[i].en;
            heartbeat = vecs[i].hb;
            x.name  = $sformatf("vec%0d", i);
            x.exp_w = vecs[i].exp_w;
`ifdef WDT_PULSE_OUT_EN
            x.exp_f = vecs[i].exp_lvl & ~prev_lvl;
`else
            x.exp_f = vecs[i].exp_lvl;
`endif
            prev_lvl = vecs[i].exp_lvl;
            sb.push_back(x);
        end
        @(posedge clk);
        #2;

        // Run to a trip, then assert an asynchronous reset between edges.
        @(negedge clk);
        enable    = 1'b1;
        heartbeat = 1'b0;
        run_idle("pre_rst");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_after_trip", warning, force_reset, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_held", warning, force_reset, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_idle("post_rst");

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
